// File: rtl/grostl_pkg.sv
// Shared types and inverse AES S-box table for the Grostl substitution layer.
package grostl_pkg;

    typedef logic [0:63][7:0] grostl_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } inv_sb_state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/grostl_inv_sbox_lut.sv
// Single-byte inverse AES S-box, combinational table lookup.
module grostl_inv_sbox_lut
    import grostl_pkg::*;
(
    input  logic [7:0] code,
    output logic [7:0] plain
);

    assign plain = INV_SBOX[code];

endmodule

// File: rtl/grostl_inv_sub_bytes_seq.sv
// Time-multiplexed inverse SubBytes over a 64-byte Grostl state.
// Define GROSTL_INV_SBOX_PIPE_EN to register S-box outputs before write-back.
module grostl_inv_sub_bytes_seq
    import grostl_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:63][7:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:63][7:0] dout,
    output logic             busy
);

    localparam int CHUNKS = 64 / LANES;
`ifdef GROSTL_INV_SBOX_PIPE_EN
    localparam int LAST = CHUNKS;
`else
    localparam int LAST = CHUNKS - 1;
`endif
    localparam int CW = (LAST > 0) ? $clog2(LAST + 1) : 1;

    if (LANES < 1 || LANES > 64 || (64 % LANES) != 0) begin : g_bad_lanes
        $error("LANES must divide 64");
    end

    inv_sb_state_t state_q, state_d;
    logic [CW-1:0] cnt_q;
    grostl_state_t st_q;

    logic [5:0] rd_base, wb_base;
    logic       wb_en;
    logic [7:0] lut_out [LANES];
    logic [7:0] wb_data [LANES];

    assign rd_base = 6'(int'(cnt_q) * LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [5:0] rd_idx;
        assign rd_idx = rd_base + 6'(l);
        grostl_inv_sbox_lut u_lut (
            .code  (st_q[rd_idx]),
            .plain (lut_out[l])
        );
    end

`ifdef GROSTL_INV_SBOX_PIPE_EN
    // Write-back trails lookup by one cycle, so it targets chunk cnt-1.
    logic [7:0] lut_q [LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) lut_q[l] <= '0;
        end else if (state_q == RUN) begin
            lut_q <= lut_out;
        end
    end

    assign wb_en   = (cnt_q != '0);
    assign wb_base = 6'((int'(cnt_q) - 1) * LANES);
    assign wb_data = lut_q;
`else
    assign wb_en   = 1'b1;
    assign wb_base = rd_base;
    assign wb_data = lut_out;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (cnt_q == CW'(LAST)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                st_q  <= din;
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= (cnt_q == CW'(LAST)) ? '0 : cnt_q + CW'(1);
                if (wb_en) begin
                    for (int l = 0; l < LANES; l++)
                        st_q[wb_base + 6'(l)] <= wb_data[l];
                end
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign dout      = st_q;

endmodule

// File: tb/tb_grostl_inv_sub_bytes_seq.sv
// Directed bench for grostl_inv_sub_bytes_seq (LANES=8), forward S-box model.
module tb_grostl_inv_sub_bytes_seq;
    import grostl_pkg::*;

    localparam int LANES  = 8;
    localparam int CHUNKS = 64 / LANES;
`ifdef GROSTL_INV_SBOX_PIPE_EN
    localparam int EXP_LAT = CHUNKS + 2;
`else
    localparam int EXP_LAT = CHUNKS + 1;
`endif

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    grostl_state_t din;
    logic          out_valid;
    logic          out_ready;
    grostl_state_t dout;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    grostl_inv_sub_bytes_seq #(.LANES(LANES)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic grostl_state_t fill(input logic [7:0] b);
        grostl_state_t s;
        for (int i = 0; i < 64; i++) s[i] = b;
        return s;
    endfunction

    // Push one state from IDLE and wait for out_valid; din is scrambled after accept.
    task automatic send(input grostl_state_t v, output int lat);
        @(negedge clk);
        din      = v;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        din      = ~v;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) check("timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int            lat;
        grostl_state_t v, orig, held;
        logic          bad_stable, bad_valid, bad_ready;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dout", dout, '0);

        send(fill(8'h63), lat);
        check("lat_63", lat, EXP_LAT);
        check("dout_63", dout, fill(8'h00));
        drain();
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);

        send(fill(8'h00), lat);
        check("dout_00", dout, fill(8'h52));
        drain();
        send(fill(8'hff), lat);
        check("dout_ff", dout, fill(8'h7d));
        drain();

        for (int i = 0; i < 64; i++) v[i] = SBOX[i];
        for (int i = 0; i < 64; i++) orig[i] = 8'(i);
        send(v, lat);
        check("index_map", dout, orig);
        drain();

        // Backpressure with in_valid held high and a different din offered
        send(fill(8'h63), lat);
        held       = dout;
        bad_stable = 1'b0;
        bad_valid  = 1'b0;
        bad_ready  = 1'b0;
        in_valid   = 1'b1;
        din        = fill(8'h11);
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (dout !== held) bad_stable = 1'b1;
            if (out_valid !== 1'b1) bad_valid = 1'b1;
            if (in_ready !== 1'b0) bad_ready = 1'b1;
        end
        check("bp_dout_stable", bad_stable, 1'b0);
        check("bp_out_valid", bad_valid, 1'b0);
        check("bp_in_ready", bad_ready, 1'b0);
        check("bp_dout_val", dout, fill(8'h00));
        in_valid = 1'b0;
        drain();
        check("bp_release_ready", in_ready, 1'b1);
        check("bp_release_valid", out_valid, 1'b0);

        // Reset while chunk 3 is in flight
        @(negedge clk);
        din      = fill(8'h63);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("run_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_dout", dout, '0);
        @(negedge clk);
        rst_n = 1'b1;
        send(fill(8'h7c), lat);
        check("post_rst_lat", lat, EXP_LAT);
        check("post_rst_dout", dout, fill(8'h01));
        drain();

        // Round trip through the forward S-box model
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 64; i++) begin
                orig[i] = 8'($urandom_range(0, 255));
                v[i]    = SBOX[orig[i]];
            end
            send(v, lat);
            check("round_trip", dout, orig);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
